routing_xbar: RTL
=================

ROUTING_XBAR -- requirements
Module: routing_xbar

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of input and output ports; legal range 2..8.
REQ-002 Parameter ROUTERID, default 0, router identity used by the static route table.
REQ-003 Parameter ROUTE_MODE, default 0: 0 = static six-node table (requires NUM_PORTS = 4); 1 = modulo routing (port = dest mod NUM_PORTS).
REQ-004 Parameter CNT_W, default 16, width of the contention counter.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pkt_in  input  NUM_PORTS x pkt_t  packet at the head of each input buffer.
REQ-008 pkt_in_avail  input  NUM_PORTS  input buffer i holds a valid packet.
REQ-009 read_from_ib  output  NUM_PORTS  one-cycle pop strobe to input buffer i; combinational, same cycle as acceptance.
REQ-010 pkt_out  output  NUM_PORTS x pkt_t  registered packet per output port.
REQ-011 pkt_out_avail  output  NUM_PORTS  registered valid per output port.
REQ-012 ob_ready_to_recv  input  NUM_PORTS  output buffer j accepts pkt_out[j] this cycle.
REQ-013 conflict_cnt  output  CNT_W  count of cycles with contention on any output.

Function
REQ-014 Route: ROUTE_MODE 0, ROUTERID even: dest 0->port 0, 1->2, 2->3, else->1; ROUTERID odd: dest 3->0, 4->1, 5->2, else->3.
REQ-015 Request: input i requests output j when pkt_in_avail[i] = 1 and route(pkt_in[i].dest) = j.
REQ-016 Each output j has an independent round-robin arbiter with pointer ptr[j] (log2 NUM_PORTS bits).
REQ-017 Winner for output j: first requesting input at index ptr[j], ptr[j]+1, ... wrapping modulo NUM_PORTS.
REQ-018 Output slot j can load when pkt_out_avail[j] = 0 or ob_ready_to_recv[j] = 1 (drain and refill in the same cycle).
REQ-019 Acceptance: winner i for output j is accepted iff slot j can load; then read_from_ib[i] = 1 that cycle.
REQ-020 On acceptance, pkt_out[j] <= pkt_in[i], pkt_out_avail[j] <= 1, ptr[j] <= (i+1) mod NUM_PORTS.
REQ-021 Slot j drained without new acceptance: pkt_out_avail[j] <= 0; pkt_out[j] holds.
REQ-022 Slot j full and ob_ready_to_recv[j] = 0: pkt_out[j], pkt_out_avail[j] and ptr[j] hold; no input routed to j is read.
REQ-023 Latency: packet accepted in cycle N appears on pkt_out with pkt_out_avail in cycle N+1; throughput one packet per output per cycle.
REQ-024 Losing requesters are not read and retry next cycle with unchanged data; no packet is dropped or duplicated.
REQ-025 Each input is read at most once per cycle (it targets exactly one output).
REQ-026 No requests for output j: ptr[j] holds.
REQ-027 conflict_cnt increments by 1 in any cycle where at least one output has two or more requesters; saturates at all-ones.

Reset
REQ-028 While reset = 1 at a clock edge: pkt_out_avail = 0, pkt_out = 0, every ptr[j] = 0, conflict_cnt = 0.
REQ-029 read_from_ib is forced to 0 while reset = 1; a packet in flight at reset is discarded from the output slot.

Structure
REQ-030 pkt_t, node/port enumerations and the route function (ROUTERID, ROUTE_MODE, dest) reside in RouterPkg.
REQ-031 Per-output arbitration is a sub-module rr_arbiter (parameter N; request, advance enable, one-hot grant), instantiated NUM_PORTS times.

Verification
REQ-032 ROUTERID 0, inputs 0 and 2 both send dest 1, all ready -> cycle 1 input 0 read, pkt_out[2] = input 0 packet; cycle 2 input 2 read; conflict_cnt = 1.
REQ-033 Four inputs continuously to dest 2 (port 3), ready = 1 -> grants rotate 0,1,2,3,0; each input served once in any 4 consecutive cycles.
REQ-034 Output 0 full, ob_ready_to_recv[0] = 0 for 5 cycles, input 1 to dest 0 -> read_from_ib[1] = 0 and pkt_out[0] stable for 5 cycles; read in the cycle ready returns.
REQ-035 Four inputs to four distinct outputs -> all four read same cycle, all four pkt_out_avail = 1 next cycle, conflict_cnt unchanged.
REQ-036 NUM_PORTS = 8, ROUTE_MODE 1, dest 13 on input 5 -> pkt_out[5] valid after one cycle.
REQ-037 Reset asserted with all slots full and contention present -> next cycle all avail = 0, reads = 0, conflict_cnt = 0; first grant after release goes to input 0.

Source files
------------

// File: rtl/routing_xbar_pkg.sv
// Shared types and routing helper for the routing crossbar.
package routing_xbar_pkg;

   localparam int unsigned DEST_W    = 4;
   localparam int unsigned SRC_W     = 4;
   localparam int unsigned PAYLOAD_W = 16;
   localparam int unsigned ROUTE_W   = 3;

   typedef struct packed {
      logic [DEST_W-1:0]    dest;
      logic [SRC_W-1:0]     src;
      logic [PAYLOAD_W-1:0] payload;
   } pkt_t;

   typedef enum logic [DEST_W-1:0] {
      NODE_0 = 4'd0,
      NODE_1 = 4'd1,
      NODE_2 = 4'd2,
      NODE_3 = 4'd3,
      NODE_4 = 4'd4,
      NODE_5 = 4'd5
   } node_e;

   typedef enum logic [ROUTE_W-1:0] {
      PORT_0 = 3'd0,
      PORT_1 = 3'd1,
      PORT_2 = 3'd2,
      PORT_3 = 3'd3
   } port_e;

   // Output port for a destination: six-node static table or dest modulo port count.
   function automatic logic [ROUTE_W-1:0] route(input int unsigned router_id,
                                                input int unsigned route_mode,
                                                input int unsigned num_ports,
                                                input logic [DEST_W-1:0] dest);
      logic [ROUTE_W-1:0] port;
      if (route_mode == 1) begin
         port = ROUTE_W'(32'(dest) % num_ports);
      end else if (router_id % 2 == 0) begin
         case (dest)
            NODE_0:  port = PORT_0;
            NODE_1:  port = PORT_2;
            NODE_2:  port = PORT_3;
            default: port = PORT_1;
         endcase
      end else begin
         case (dest)
            NODE_3:  port = PORT_0;
            NODE_4:  port = PORT_1;
            NODE_5:  port = PORT_2;
            default: port = PORT_3;
         endcase
      end
      return port;
   endfunction

endpackage

// File: rtl/routing_xbar_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         adv,
   output logic [N-1:0] grant_c
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   logic          found;
   int            idx;

   // Scan requesters starting at the pointer, wrapping around
   always_comb begin
      grant_c = '0;
      found   = 1'b0;
      ptr_nxt = ptr;
      idx     = 0;
      for (int k = 0; k < int'(N); k++) begin
         idx = (int'(ptr) + k) % int'(N);
         if (!found && req[idx]) begin
            found        = 1'b1;
            grant_c[idx] = 1'b1;
            ptr_nxt      = PW'((idx + 1) % int'(N));
         end
      end
   end

   // Pointer moves past the winner only when its grant is actually taken
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr <= '0;
      end else if (adv && found) begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/routing_xbar.sv
// Input-buffered crossbar with per-output round-robin arbitration and registered output slots.
module routing_xbar
   import routing_xbar_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned ROUTERID   = 0,
   parameter int unsigned ROUTE_MODE = 0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  pkt_t [NUM_PORTS-1:0]   pkt_in,
   input  logic [NUM_PORTS-1:0]   pkt_in_avail,
   output logic [NUM_PORTS-1:0]   read_from_ib,
   output pkt_t [NUM_PORTS-1:0]   pkt_out,
   output logic [NUM_PORTS-1:0]   pkt_out_avail,
   input  logic [NUM_PORTS-1:0]   ob_ready_to_recv,
   output logic [CNT_W-1:0]       conflict_cnt
);

   localparam int unsigned PW = $clog2(NUM_PORTS);

   logic [PW-1:0]        dest_port [NUM_PORTS];
   logic [NUM_PORTS-1:0] req       [NUM_PORTS];
   logic [NUM_PORTS-1:0] grant     [NUM_PORTS];
   logic [NUM_PORTS-1:0] can_load;
   logic [NUM_PORTS-1:0] accept;
   pkt_t [NUM_PORTS-1:0] sel;
   logic                 conflict;

   // Route each input's head packet to an output index
   always_comb begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         dest_port[i] = PW'(route(ROUTERID, ROUTE_MODE, NUM_PORTS, pkt_in[i].dest));
      end
   end

   // Request matrix (req[j][i]: input i wants output j), slot load condition, contention
   always_comb begin
      conflict = 1'b0;
      can_load = '0;
      for (int j = 0; j < int'(NUM_PORTS); j++) begin
         req[j]      = '0;
         can_load[j] = !pkt_out_avail[j] || ob_ready_to_recv[j];
         for (int i = 0; i < int'(NUM_PORTS); i++) begin
            req[j][i] = pkt_in_avail[i] && (dest_port[i] == PW'(j));
         end
         if ($countones(req[j]) > 1) begin
            conflict = 1'b1;
         end
      end
   end

   for (genvar j = 0; j < int'(NUM_PORTS); j++) begin : g_arb
      rr_arbiter #(.N(NUM_PORTS)) u_arb (
         .clock   (clock),
         .reset   (reset),
         .req     (req[j]),
         .adv     (can_load[j]),
         .grant_c (grant[j])
      );
   end

   // Winner mux per output and pop strobes for accepted inputs
   always_comb begin
      read_from_ib = '0;
      sel          = '0;
      accept       = '0;
      for (int j = 0; j < int'(NUM_PORTS); j++) begin
         accept[j] = can_load[j] && (|req[j]);
         for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (grant[j][i]) begin
               sel[j] = pkt_in[i];
               if (can_load[j] && !reset) begin
                  read_from_ib[i] = 1'b1;
               end
            end
         end
      end
   end

   // Output slots: load on acceptance, clear valid on drain; saturating contention count
   always_ff @(posedge clock) begin
      if (reset) begin
         pkt_out       <= '0;
         pkt_out_avail <= '0;
         conflict_cnt  <= '0;
      end else begin
         for (int j = 0; j < int'(NUM_PORTS); j++) begin
            if (accept[j]) begin
               pkt_out[j]       <= sel[j];
               pkt_out_avail[j] <= 1'b1;
            end else if (ob_ready_to_recv[j]) begin
               pkt_out_avail[j] <= 1'b0;
            end
         end
         if (conflict && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
         end
      end
   end

endmodule
